// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single SDRAM controller burst port among video DMA, cache line
// fill and write-merge buffer; one requester owns the port per BURST_LEN-beat burst.
module sdram_port_arbiter #(
  parameter int BURST_LEN  = 4,
  parameter int WB_MAXWAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [31:0] vid_addr,
  output logic        vid_fill,
  input  logic        cache_req,
  input  logic [31:0] cache_addr,
  output logic        cache_fill,
  input  logic        wb_req,
  input  logic [31:0] wb_addr,
  input  logic [15:0] wb_data,
  input  logic [1:0]  wb_dqm,
  output logic        wb_next,
  output logic [15:0] rd_data,
  output logic        sdram_req,
  output logic        sdram_rw,
  output logic [31:0] sdram_addr,
  output logic [15:0] sdram_wdata,
  output logic [1:0]  sdram_dqm,
  input  logic        sdram_ack,
  input  logic        sdram_fill,
  input  logic        sdram_wrnext,
  input  logic [15:0] sdram_rdata,
  output logic [1:0]  grant
);

  localparam int            WW        = $clog2(WB_MAXWAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(WB_MAXWAIT);
  localparam logic [1:0]    LAST_BEAT = 2'(BURST_LEN - 1);
  localparam logic [1:0]    G_NONE    = 2'd0;
  localparam logic [1:0]    G_VID     = 2'd1;
  localparam logic [1:0]    G_CACHE   = 2'd2;
  localparam logic [1:0]    G_WB      = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, BURST, RECOVER} state_t;

  state_t        state_q;
  logic [1:0]    grant_q;
  logic [1:0]    beat_q;
  logic [WW-1:0] wait_q;
  logic [WW-1:0] wait_d;
  logic          req_q;
  logic          rw_q;
  logic [31:0]   addr_q;
  logic [1:0]    pick_s;
  logic [31:0]   pick_addr_s;
  logic          wb_promote_s;
  logic          beat_s;
  logic          grant_wr_s;

  // Write-buffer wait counter: ages a pending write that is not being served.
  always_comb begin
    wait_d = wait_q;
    if (!wb_req || grant_q == G_WB) begin
      wait_d = '0;
    end else if (wait_q < WAIT_MAX) begin
      wait_d = wait_q + WW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Fixed priority video > cache > write, with an aged write promoted over cache.
  always_comb begin
    wb_promote_s = wb_req && (wait_q >= WAIT_MAX);
    pick_s       = G_NONE;
    pick_addr_s  = 32'h0000_0000;
    if (vid_req) begin
      pick_s      = G_VID;
      pick_addr_s = vid_addr;
    end else if (wb_promote_s) begin
      pick_s      = G_WB;
      pick_addr_s = wb_addr;
    end else if (cache_req) begin
      pick_s      = G_CACHE;
      pick_addr_s = cache_addr;
    end else if (wb_req) begin
      pick_s      = G_WB;
      pick_addr_s = wb_addr;
    end else begin
      pick_s      = G_NONE;
      pick_addr_s = 32'h0000_0000;
    end
  end

  // A beat is a read fill or a write take, depending on the burst direction.
  always_comb begin
    beat_s     = rw_q ? sdram_fill : sdram_wrnext;
    grant_wr_s = (grant_q == G_WB) && reset;
  end

  // Burst sequencer; owns every registered output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= G_NONE;
      req_q   <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= 32'h0000_0000;
      beat_q  <= 2'd0;
      wait_q  <= '0;
    end else begin
      wait_q <= wait_d;
      case (state_q)
        IDLE: begin
          if (pick_s != G_NONE) begin
            grant_q <= pick_s;
            rw_q    <= (pick_s != G_WB);
            addr_q  <= pick_addr_s & 32'hFFFF_FFF8;
            req_q   <= 1'b1;
            beat_q  <= 2'd0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (beat_s) begin
            if (beat_q == LAST_BEAT) begin
              beat_q  <= 2'd0;
              grant_q <= G_NONE;
              state_q <= RECOVER;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        RECOVER: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= G_NONE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are steered by the registered grant and silenced while in reset.
  assign vid_fill    = sdram_fill   && (grant_q == G_VID)   && reset;
  assign cache_fill  = sdram_fill   && (grant_q == G_CACHE) && reset;
  assign wb_next     = sdram_wrnext && grant_wr_s;
  assign sdram_wdata = grant_wr_s ? wb_data : 16'h0000;
  assign sdram_dqm   = grant_wr_s ? wb_dqm  : 2'b11;
  assign rd_data     = sdram_rdata;
  assign sdram_req   = req_q;
  assign sdram_rw    = rw_q;
  assign sdram_addr  = addr_q;
  assign grant       = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_sdram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, vid_req, cache_req, wb_req;
  logic [31:0] vid_addr, cache_addr, wb_addr;
  logic [15:0] wb_data, sdram_rdata;
  logic [1:0]  wb_dqm;
  logic        sdram_ack, sdram_fill, sdram_wrnext;
  logic        vid_fill, cache_fill, wb_next, sdram_req, sdram_rw;
  logic [15:0] rd_data, sdram_wdata;
  logic [31:0] sdram_addr;
  logic [1:0]  sdram_dqm, grant;

  sdram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_fill(vid_fill),
    .cache_req(cache_req), .cache_addr(cache_addr), .cache_fill(cache_fill),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_dqm(wb_dqm),
    .wb_next(wb_next), .rd_data(rd_data),
    .sdram_req(sdram_req), .sdram_rw(sdram_rw), .sdram_addr(sdram_addr),
    .sdram_wdata(sdram_wdata), .sdram_dqm(sdram_dqm),
    .sdram_ack(sdram_ack), .sdram_fill(sdram_fill), .sdram_wrnext(sdram_wrnext),
    .sdram_rdata(sdram_rdata), .grant(grant)
  );

  int vectors = 0;
  int errs    = 0;

  // Reference model: owner of the port, beats still owed, recovery gap, write age.
  int          m_grant, m_left, m_wait;
  bit          m_req, m_rw, m_recover;
  logic [31:0] m_addr;

  // Controller / write-buffer behaviour knobs.
  int          ack_delay, fill_pct, iss_cnt, wi, cyc;
  bit          stray_en, force_fill;
  logic [15:0] rd_seq;
  logic [15:0] wdat [4];
  logic [1:0]  wdqm [4];

  // Observations of DUT strobes for directed checks.
  int          obs_vid, obs_cache, obs_wb, vid_in_cache;
  logic [15:0] last_rd;
  logic [1:0]  prev_g;
  logic [31:0] q_wd [$];
  int          q_g [$];
  int          q_start [$];
  int          q_end [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_grant = 0; m_left = 0; m_wait = 0;
    m_req = 1'b0; m_rw = 1'b1; m_recover = 1'b0; m_addr = 32'h0;
  endtask

  task automatic model_tick();
    int w_old;
    int pick;
    w_old = m_wait;
    if (!reset) begin
      model_reset();
    end else begin
      if (!wb_req || m_grant == 3) m_wait = 0;
      else if (m_wait < 15) m_wait = m_wait + 1;
      if (m_recover) begin
        m_recover = 1'b0;
      end else if (m_grant == 0) begin
        if (vid_req) pick = 1;
        else if (wb_req && w_old >= 15) pick = 3;
        else if (cache_req) pick = 2;
        else if (wb_req) pick = 3;
        else pick = 0;
        if (pick != 0) begin
          m_grant = pick;
          m_req   = 1'b1;
          m_rw    = (pick != 3);
          m_addr  = (pick == 1 ? vid_addr : pick == 2 ? cache_addr : wb_addr) & 32'hFFFF_FFF8;
          m_left  = 4;
        end
      end else if (m_req) begin
        if (sdram_ack) m_req = 1'b0;
      end else if (m_rw ? sdram_fill : sdram_wrnext) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_grant   = 0;
          m_recover = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive controller, check combinational outputs, clock, check registers.
  task automatic cycle();
    bit in_burst, exp_wbn, prev_req;
    in_burst     = (m_grant != 0) && !m_req;
    sdram_ack    = m_req && (iss_cnt >= ack_delay);
    sdram_fill   = force_fill || (in_burst && m_rw && int'($urandom_range(99)) < fill_pct)
                   || (stray_en && $urandom_range(15) == 0);
    sdram_wrnext = (in_burst && !m_rw && int'($urandom_range(99)) < fill_pct)
                   || (stray_en && $urandom_range(15) == 0);
    sdram_rdata  = rd_seq;
    wb_data      = wdat[wi];
    wb_dqm       = wdqm[wi];
    #1;
    exp_wbn = sdram_wrnext && m_grant == 3 && reset;
    chk("vid_fill", 32'(vid_fill), 32'(sdram_fill && m_grant == 1 && reset));
    chk("cache_fill", 32'(cache_fill), 32'(sdram_fill && m_grant == 2 && reset));
    chk("wb_next", 32'(wb_next), 32'(exp_wbn));
    chk("rd_data", 32'(rd_data), 32'(sdram_rdata));
    chk("sdram_wdata", 32'(sdram_wdata), (m_grant == 3 && reset) ? 32'(wb_data) : 32'h0);
    chk("sdram_dqm", 32'(sdram_dqm), (m_grant == 3 && reset) ? 32'(wb_dqm) : 32'h3);
    if (vid_fill === 1'b1) obs_vid++;
    if (cache_fill === 1'b1) begin
      obs_cache++;
      last_rd = rd_data;
    end
    if (wb_next === 1'b1) begin
      obs_wb++;
      q_wd.push_back({14'h0, sdram_dqm, sdram_wdata});
    end
    if (vid_fill === 1'b1 && grant === 2'd2) vid_in_cache++;
    @(posedge clk);
    if (exp_wbn) wi = (wi + 1) % 4;
    if (sdram_fill) rd_seq = rd_seq + 16'd1;
    prev_req = m_req;
    model_tick();
    iss_cnt = (m_req && prev_req) ? iss_cnt + 1 : 0;
    #1;
    cyc++;
    chk("grant", 32'(grant), 32'(m_grant));
    chk("sdram_req", 32'(sdram_req), 32'(m_req));
    chk("sdram_rw", 32'(sdram_rw), 32'(m_rw));
    chk("sdram_addr", sdram_addr, m_addr);
    if (grant !== prev_g) begin
      if (grant != 2'd0) begin
        q_g.push_back(int'(grant));
        q_start.push_back(cyc);
      end else begin
        q_end.push_back(cyc);
      end
      prev_g = grant;
    end
  endtask

  task automatic clear_obs();
    obs_vid = 0; obs_cache = 0; obs_wb = 0; vid_in_cache = 0;
    q_wd.delete(); q_g.delete(); q_start.delete(); q_end.delete();
  endtask

  // Run until the model returns to an unowned, non-recovering port (bounded).
  task automatic drain(input string tag, input int budget);
    int k;
    for (k = 0; k < budget && (m_grant != 0 || m_recover); k++) cycle();
    chk(tag, 32'(m_grant == 0 && !m_recover), 32'h1);
  endtask

  initial begin
    int k;
    reset = 1'b0; vid_req = 1'b0; cache_req = 1'b0; wb_req = 1'b0;
    vid_addr = 32'h0; cache_addr = 32'h0; wb_addr = 32'h0;
    sdram_ack = 1'b0; sdram_fill = 1'b0; sdram_wrnext = 1'b0; sdram_rdata = 16'h0;
    wb_data = 16'h0; wb_dqm = 2'b00;
    ack_delay = 0; fill_pct = 100; iss_cnt = 0; wi = 0; cyc = 0;
    stray_en = 1'b0; force_fill = 1'b0; rd_seq = 16'h0; prev_g = 2'd0; last_rd = 16'h0;
    for (int i = 0; i < 4; i++) begin wdat[i] = 16'h0; wdqm[i] = 2'b00; end
    model_reset();
    clear_obs();

    // Reset state.
    repeat (3) cycle();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_rw", 32'(sdram_rw), 32'h1);
    chk("rst_addr", sdram_addr, 32'h0);
    chk("rst_req", 32'(sdram_req), 32'h0);
    reset = 1'b1;
    cycle();

    // Single cache read.
    clear_obs();
    ack_delay = 2; fill_pct = 100; rd_seq = 16'hA000;
    cache_req = 1'b1; cache_addr = 32'h0001_2346;
    cycle();
    chk("cache_addr_latched", sdram_addr, 32'h0001_2340);
    chk("cache_rw", 32'(sdram_rw), 32'h1);
    chk("cache_grant", 32'(grant), 32'h2);
    for (k = 0; k < 30 && !(m_recover); k++) begin
      if (obs_cache > 0) cache_req = 1'b0;
      cycle();
    end
    cache_req = 1'b0;
    drain("cache_done", 10);
    chk("cache_fill_count", 32'(obs_cache), 32'd4);
    chk("cache_last_data", 32'(last_rd), 32'h0000_A003);
    chk("cache_grant_idle", 32'(grant), 32'h0);

    // Contention: video and cache raised together.
    clear_obs();
    ack_delay = 1; fill_pct = 70;
    vid_req = 1'b1; vid_addr = 32'h0000_4007;
    cache_req = 1'b1; cache_addr = 32'h0000_8000;
    for (k = 0; k < 80 && q_end.size() < 2; k++) begin
      if (obs_vid > 0) vid_req = 1'b0;
      if (obs_cache > 0) cache_req = 1'b0;
      cycle();
    end
    vid_req = 1'b0; cache_req = 1'b0;
    chk("cont_bursts", 32'(q_end.size()), 32'd2);
    if (q_g.size() >= 2 && q_end.size() >= 1) begin
      chk("cont_first", 32'(q_g[0]), 32'd1);
      chk("cont_second", 32'(q_g[1]), 32'd2);
      // RECOVER plus exactly one IDLE cycle separate the two grants.
      chk("cont_gap", 32'(q_start[1] - q_end[0]), 32'd2);
    end
    chk("cont_vid_fill", 32'(obs_vid), 32'd4);
    chk("cont_vid_in_cache", 32'(vid_in_cache), 32'd0);
    drain("cont_done", 10);

    // Write burst with per-beat data and masks.
    clear_obs();
    ack_delay = 1; fill_pct = 60; wi = 0;
    wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333; wdat[3] = 16'h4444;
    wdqm[0] = 2'b00;    wdqm[1] = 2'b10;    wdqm[2] = 2'b01;    wdqm[3] = 2'b00;
    wb_req = 1'b1; wb_addr = 32'h0000_0100;
    cycle();
    chk("wr_rw", 32'(sdram_rw), 32'h0);
    chk("wr_addr", sdram_addr, 32'h0000_0100);
    for (k = 0; k < 40 && !(m_recover); k++) begin
      if (obs_wb > 0) wb_req = 1'b0;
      cycle();
    end
    wb_req = 1'b0;
    drain("wr_done", 10);
    chk("wr_next_count", 32'(obs_wb), 32'd4);
    if (q_wd.size() == 4) begin
      chk("wr_beat0", q_wd[0], 32'h0000_1111);
      chk("wr_beat1", q_wd[1], 32'h0002_2222);
      chk("wr_beat2", q_wd[2], 32'h0001_3333);
      chk("wr_beat3", q_wd[3], 32'h0000_4444);
    end
    chk("wr_dqm_idle", 32'(sdram_dqm), 32'h3);

    // Starvation: cache held, write must be promoted after aging.
    clear_obs();
    ack_delay = 0; fill_pct = 100;
    cache_req = 1'b1; cache_addr = 32'h0000_2000;
    wb_req = 1'b1; wb_addr = 32'h0000_3000;
    for (k = 0; k < 200 && m_grant != 3; k++) cycle();
    chk("starve_wr_granted", 32'(m_grant), 32'd3);
    chk("starve_cache_before", 32'(q_g.size() - 1), 32'd3);
    for (k = 0; k < 60 && q_g.size() < 5; k++) cycle();
    if (q_g.size() >= 5) chk("starve_after_wr", 32'(q_g[4]), 32'd2);
    else chk("starve_after_wr_timeout", 32'(q_g.size()), 32'd5);
    cache_req = 1'b0; wb_req = 1'b0;
    drain("starve_done", 20);
    cycle();

    // Reset after the second fill of a cache burst.
    clear_obs();
    ack_delay = 1; fill_pct = 100;
    cache_req = 1'b1; cache_addr = 32'h0000_5550;
    for (k = 0; k < 30 && !(m_grant == 2 && m_left == 2); k++) cycle();
    chk("rstmid_reached", 32'(m_left), 32'd2);
    reset = 1'b0; force_fill = 1'b1;
    cycle();
    chk("rstmid_grant", 32'(grant), 32'h0);
    chk("rstmid_req", 32'(sdram_req), 32'h0);
    reset = 1'b1; cache_req = 1'b0;
    k = obs_cache;
    cycle();
    chk("rstmid_stray", 32'(obs_cache - k), 32'd0);
    force_fill = 1'b0;
    cycle();

    // Video request dropped while the burst is being issued.
    clear_obs();
    ack_delay = 3; fill_pct = 80;
    vid_req = 1'b1; vid_addr = 32'h0ABC_DEF5;
    cycle();
    vid_req = 1'b0; vid_addr = 32'h1234_5678;
    for (k = 0; k < 40 && !(m_recover); k++) begin
      cycle();
      if (m_grant == 1) chk("drop_addr", sdram_addr, 32'h0ABC_DEF0);
    end
    drain("drop_done", 10);
    chk("drop_vid_fill", 32'(obs_vid), 32'd4);

    // Randomized traffic with stray strobes and occasional resets.
    stray_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) begin
        ack_delay = int'($urandom_range(3));
        fill_pct  = 30 + int'($urandom_range(70));
      end
      if (!vid_req && $urandom_range(7) == 0) begin
        vid_req = 1'b1; vid_addr = $urandom;
      end else if (vid_req && ((m_grant == 1 && !m_req) || $urandom_range(63) == 0)) begin
        vid_req = 1'b0;
      end
      if (!cache_req && $urandom_range(5) == 0) begin
        cache_req = 1'b1; cache_addr = $urandom;
      end else if (cache_req && ((m_grant == 2 && !m_req) || $urandom_range(63) == 0)) begin
        cache_req = 1'b0;
      end
      if (!wb_req && $urandom_range(5) == 0) begin
        wb_req = 1'b1; wb_addr = $urandom;
      end else if (wb_req && m_grant == 3 && !m_req) begin
        wb_req = 1'b0;
      end
      wdat[$urandom_range(3)] = 16'($urandom);
      wdqm[$urandom_range(3)] = 2'($urandom);
      reset = ($urandom_range(299) != 0);
      cycle();
    end
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller burst port among three requesters: video DMA (read), two-way cache line fill (read) and write-merge buffer (write).
- Grants one requester per 4-word burst, latches its address and routes fill/write strobes to the granted port only.
- Uses fixed priority with write-buffer anti-starvation promotion.
- Sits between the cache/DMA/write buffer and the SDRAM controller.

Parameters:
- BURST_LEN, 4, beats per burst; beat counter is 2 bits.
- WB_MAXWAIT, 15, cycles a pending write may wait before it is promoted above the cache.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- vid_req  in  1  video DMA burst request; hold until first vid_fill
- vid_addr  in  32  video burst address; bits 2:0 ignored
- vid_fill  out  1  read beat valid for video
- cache_req  in  1  cache fill request; hold until first cache_fill
- cache_addr  in  32  cache fill address; bits 2:0 ignored
- cache_fill  out  1  read beat valid for cache
- wb_req  in  1  write buffer burst request
- wb_addr  in  32  write burst address
- wb_data  in  16  current write word; buffer advances on wb_next
- wb_dqm  in  2  byte masks for current word; 1 = masked
- wb_next  out  1  write beat consumed; buffer presents next word
- rd_data  out  16  read data broadcast (= sdram_rdata)
- sdram_req  out  1  burst request to controller
- sdram_rw  out  1  1 = read, 0 = write
- sdram_addr  out  32  latched burst address, bits 2:0 forced 0
- sdram_wdata  out  16  wb_data while write granted, else 0
- sdram_dqm  out  2  wb_dqm while write granted, else 2'b11
- sdram_ack  in  1  controller accepted request (1-cycle pulse)
- sdram_fill  in  1  read beat valid
- sdram_wrnext  in  1  write beat taken
- sdram_rdata  in  16  read data
- grant  out  2  0 = none, 1 = video, 2 = cache, 3 = write

Behaviour:
- Reset values (while reset = 0, overrides everything):
  - state = IDLE, grant = 0, sdram_req = 0, sdram_rw = 1, sdram_addr = 0
  - beat counter = 0, wait counter = 0
  - vid_fill, cache_fill and wb_next held 0
- Reset during a burst abandons it; the controller is reset by the same signal.
- States:
  - IDLE: evaluate requests; on any request, latch address, set grant and sdram_rw, assert sdram_req -> ISSUE.
  - ISSUE: hold sdram_req until sdram_ack; on ack drop sdram_req -> BURST.
  - BURST: count sdram_fill (read) or sdram_wrnext (write) beats; beat BURST_LEN -> RECOVER.
  - RECOVER: 1 cycle, grant = 0 -> IDLE. Minimum request-to-request spacing is one idle cycle.
- Priority in IDLE:
  - Video first, then cache, then write.
  - Exception: if wb_req is set and wait counter >= WB_MAXWAIT, write beats cache. Video is never preempted.
- Wait counter:
  - Increments each cycle wb_req = 1 and grant != 3, saturating at WB_MAXWAIT.
  - Clears when write is granted or wb_req = 0.
- Strobe gating (combinational):
  - vid_fill = sdram_fill & grant == 1
  - cache_fill = sdram_fill & grant == 2
  - wb_next = sdram_wrnext & grant == 3
- sdram_fill/sdram_wrnext seen outside BURST are ignored and not counted.
- A request dropped after grant does not abort the burst; beats still complete and are routed to that port.
- Simultaneous requests in the same cycle resolve strictly by the priority above; losers stay pending.
- rd_data is unregistered, with zero added latency.

Test Plan:
- Single cache read:
  - Stimulus: cache_req = 1, cache_addr = 0x00012346; ack 2 cycles later; 4 fills of 0xA000..0xA003.
  - Response: sdram_addr = 0x00012340, sdram_rw = 1, cache_fill pulses 4x, grant returns 0 after RECOVER.
- Contention:
  - Stimulus: vid_req and cache_req asserted in the same cycle.
  - Response: video burst first (grant = 1); cache granted exactly one idle cycle after video's 4th fill; vid_fill never set during the cache burst.
- Write burst:
  - Stimulus: wb_req, wb_addr = 0x100, data 0x1111/0x2222/0x3333/0x4444, dqm 00, 10, 01, 00.
  - Response: sdram_rw = 0; sdram_wdata/sdram_dqm track per wrnext; wb_next pulses 4x; sdram_dqm = 11 outside the grant.
- Starvation:
  - Stimulus: cache_req held continuously, wb_req asserted.
  - Response: write granted at the first IDLE after its wait counter reaches 15; wait counter then clears.
- Reset mid-burst:
  - Stimulus: reset = 0 after the 2nd fill of a cache burst.
  - Response: next cycle state = IDLE, sdram_req = 0, grant = 0; stray sdram_fill produces no cache_fill.
- Early request drop:
  - Stimulus: vid_req dropped in ISSUE.
  - Response: burst still completes with 4 vid_fill pulses; sdram_addr remains the latched value.
